nibble_serial_sub: RTL and testbench

- Multi-cycle subtractor computing D = A - B - BI, one 4-bit nibble per clock, LSB nibble first.
- The borrow between nibbles is held in a flop.
- Companion to the 4-bit-block lookahead adder in the datapath library. Used where area matters more than latency, e.g. address/offset decrement and compare paths.
- Start/done handshake; operands are captured at start, the result is registered at completion.

---
 rtl/sub_pkg.sv | 17 +
 rtl/nibble_sub_block.sv | 28 ++
 rtl/nibble_serial_sub.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_sub.sv | 128 ++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants, FSM state type and counter sizing for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for Width/NIBBLE nibbles; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width / NIBBLE > 1) ? $clog2(width / NIBBLE) : 1;
  endfunction

endpackage

// File: rtl/nibble_sub_block.sv
// 4-bit subtract slice: a - b - bin via a + ~b + ~bin using generate/propagate lookahead.
module nibble_sub_block
  import sub_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              bin,
  output logic [NIBBLE-1:0] d,
  output logic              bout
);

  logic [NIBBLE-1:0] g, p;
  logic [NIBBLE:0]   c;

  always_comb begin
    g    = a & ~b;
    p    = a ^ ~b;
    c[0] = ~bin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    d    = p ^ c[NIBBLE-1:0];
    bout = ~c[4];
  end

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle D = A - B - BI, one nibble per clock, LSB first, start/done handshake.
// Optional signed overflow output enabled by defining NIBBLE_SUB_SIGNED_OVF_EN.
module nibble_serial_sub
  import sub_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             BI,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] D,
  output logic             BO,
  output logic             OV
);

  localparam int N  = Width / NIBBLE;
  localparam int CW = cnt_w(Width);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((Width % NIBBLE) != 0 || Width < NIBBLE) begin : g_bad_width
      $error("nibble_serial_sub: Width must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic [Width-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, res_next;
  logic [Width-1:0]  d_q, d_d;
  logic              bo_q, bo_d, done_q, done_d, busy_q, busy_d;
  logic [NIBBLE-1:0] blk_d;
  logic              blk_bo;

  // Operands shift right each RUN cycle so the active nibble is always at [3:0].
  nibble_sub_block u_blk (
    .a    (a_q[NIBBLE-1:0]),
    .b    (b_q[NIBBLE-1:0]),
    .bin  (borrow_q),
    .d    (blk_d),
    .bout (blk_bo)
  );

`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  logic asgn_q, asgn_d, bsgn_q, bsgn_d, ov_q, ov_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    bo_d     = bo_q;
    done_d   = 1'b0;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
    asgn_d   = asgn_q;
    bsgn_d   = bsgn_q;
    ov_d     = ov_q;
`endif
    res_next = res_q >> NIBBLE;
    res_next[Width-1 -: NIBBLE] = blk_d;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = BI;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
          asgn_d   = A[Width-1];
          bsgn_d   = B[Width-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> NIBBLE;
        b_d      = b_q >> NIBBLE;
        res_d    = res_next;
        borrow_d = blk_bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = res_next;
          bo_d    = blk_bo;
          done_d  = 1'b1;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
          ov_d    = (asgn_q != bsgn_q) && (res_next[Width-1] != asgn_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asgn_q <= 1'b0;
      bsgn_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      asgn_q <= asgn_d;
      bsgn_q <= bsgn_d;
      ov_q   <= ov_d;
    end
  end
  assign OV = ov_q;
`else
  assign OV = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign BO   = bo_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed-vector bench for nibble_serial_sub at Width=8.
module tb_nibble_serial_sub;

`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  localparam logic OV_EN = 1'b1;
`else
  localparam logic OV_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       BI = 1'b0;
  logic       busy, done, BO, OV;
  logic [7:0] D;

  int total = 0;
  int bad = 0;

  nibble_serial_sub #(.Width(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .BI(BI),
    .busy(busy), .done(done), .D(D), .BO(BO), .OV(OV)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; sample point sits 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: start on edge 0, busy in cycles 1-2, done in cycle 3 only.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] exp_d, input logic exp_bo,
                        input logic exp_ov);
    A = a; B = b; BI = bi; start = 1'b1;
    tick();
    start = 1'b0; A = ~a; B = ~b; BI = ~bi;
    chk({tag, ".c1busy"}, 32'(busy), 32'd1);
    chk({tag, ".c1done"}, 32'(done), 32'd0);
    tick();
    chk({tag, ".c2busy"}, 32'(busy), 32'd1);
    chk({tag, ".c2done"}, 32'(done), 32'd0);
    tick();
    chk({tag, ".c3busy"}, 32'(busy), 32'd0);
    chk({tag, ".c3done"}, 32'(done), 32'd1);
    chk({tag, ".D"},  32'(D),  32'(exp_d));
    chk({tag, ".BO"}, 32'(BO), 32'(exp_bo));
    chk({tag, ".OV"}, 32'(OV), 32'(exp_ov));
    tick();
    chk({tag, ".c4done"}, 32'(done), 32'd0);
    chk({tag, ".Dhold"},  32'(D),    32'(exp_d));
  endtask

  initial begin
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.D",    32'(D),    32'd0);
    chk("rst.BO",   32'(BO),   32'd0);
    chk("rst.OV",   32'(OV),   32'd0);
    tick();
    reset = 1'b0;
    tick();

    run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("wrap",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("bprop", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);

    // start in RUN ignored; held start accepted in DONE for back-to-back ops.
    A = 8'h20; B = 8'h01; BI = 1'b0; start = 1'b1;
    tick();
    A = 8'hFF; B = 8'hFF;
    tick();
    chk("b2b.c2busy", 32'(busy), 32'd1);
    tick();
    chk("b2b.c3done", 32'(done), 32'd1);
    chk("b2b.D1",     32'(D),    32'h1F);
    chk("b2b.BO1",    32'(BO),   32'd0);
    tick();
    start = 1'b0;
    chk("b2b.c4busy", 32'(busy), 32'd1);
    chk("b2b.c4done", 32'(done), 32'd0);
    chk("b2b.c4D",    32'(D),    32'h1F);
    tick();
    chk("b2b.c5busy", 32'(busy), 32'd1);
    tick();
    chk("b2b.c6done", 32'(done), 32'd1);
    chk("b2b.D2",     32'(D),    32'h00);
    chk("b2b.BO2",    32'(BO),   32'd0);
    tick();

    // Reset mid-RUN aborts with no done pulse.
    run_op("pre", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    A = 8'h77; B = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.D",    32'(D),    32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort.nodone", 32'(done), 32'd0);
    end
    run_op("after", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    run_op("ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OV_EN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
